// File: rtl/spi_flash_responder.sv
// spi_flash_responder: SPI mode-0 flash slave answering READ (0x03) from a word-wide store
//   clock, reset      system clock, async active-low reset
//   spi_sck/ss/mosi   SPI pins from the master (oversampled), spi_miso back
//   mem_en/mem_addr   one-cycle word fetch strobe and word address
//   mem_rdata         fetched word, valid the cycle after mem_en, byte 0 in [7:0]
//   active, bad_cmd   selected and busy, one-cycle unknown-command pulse
module spi_flash_responder #(
   parameter int ADDR_BITS = 24,
   parameter int SS_INDEX  = 0,
   parameter int SS_NUM    = 8
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 spi_sck,
   input  logic [SS_NUM-1:0]    spi_ss,
   input  logic                 spi_mosi,
   output logic                 spi_miso,
   output logic                 mem_en,
   output logic [ADDR_BITS-3:0] mem_addr,
   input  logic [31:0]          mem_rdata,
   output logic                 active,
   output logic                 bad_cmd
);
   typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, IGNORE} state_t;
   state_t state, state_nx;
   logic [2:0] sck_q;
   logic [1:0] ss_q, mosi_q;
   logic [4:0] cnt;
   logic [22:0] sh;
   logic [23:0] shin;
   logic [ADDR_BITS-1:0] byte_addr, addr_inc;
   logic [31:0] word_buf;
   logic fetch, rise, fall, ss_off, cmd_done, addr_done, byte_done, wrap_fetch;
   assign rise = sck_q[1] & ~sck_q[2];
   assign fall = ~sck_q[1] & sck_q[2];
   assign ss_off = ss_q[1];
   assign shin = {sh, mosi_q[1]};
   assign addr_inc = byte_addr + ADDR_BITS'(1);
   assign active = (state != IDLE) & ~ss_off;
   // SS deassertion gates every edge so it always wins over a coincident SCK edge
   assign cmd_done = ~ss_off && state == CMD && rise && cnt == 5'd7;
   assign addr_done = ~ss_off && state == ADDR && rise && cnt == 5'd23;
   assign byte_done = ~ss_off && state == DATA && fall && cnt[2:0] == 3'd0;
   assign wrap_fetch = byte_done && addr_inc[1:0] == 2'd0;
   always_comb begin
      state_nx = ss_off ? IDLE :
                 state == IDLE ? CMD :
                 cmd_done ? (shin[7:0] == 8'h03 ? ADDR : IGNORE) :
                 addr_done ? DATA : state;
   end
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         sck_q <= '0;
         ss_q <= 2'b11;
         mosi_q <= '0;
         cnt <= '0;
         sh <= '0;
         byte_addr <= '0;
         word_buf <= '0;
         fetch <= 1'b0;
         spi_miso <= 1'b0;
         mem_en <= 1'b0;
         mem_addr <= '0;
         bad_cmd <= 1'b0;
      end else begin
         state <= state_nx;
         sck_q <= {sck_q[1:0], spi_sck};
         ss_q <= {ss_q[0], spi_ss[SS_INDEX]};
         mosi_q <= {mosi_q[0], spi_mosi};
         bad_cmd <= cmd_done && shin[7:0] != 8'h03;
         mem_en <= addr_done | wrap_fetch;
         if (addr_done) mem_addr <= shin[ADDR_BITS-1:2];
         else if (wrap_fetch) mem_addr <= addr_inc[ADDR_BITS-1:2];
         fetch <= mem_en;
         if (fetch) word_buf <= mem_rdata;
         // cnt counts shifted bits in CMD/ADDR, then is reused as the MSB-first bit index in DATA
         if (state == IDLE || ss_off) begin
            cnt <= '0;
            sh <= '0;
         end else if (rise && (state == CMD || state == ADDR)) begin
            sh <= shin[22:0];
            cnt <= cmd_done ? 5'd0 : addr_done ? 5'd7 : cnt + 5'd1;
         end else if (fall && state == DATA) cnt <= cnt - 5'd1;
         if (addr_done) byte_addr <= shin[ADDR_BITS-1:0];
         else if (byte_done) byte_addr <= addr_inc;
         spi_miso <= (state != DATA || ss_off) ? 1'b0 :
                     fall ? word_buf[{byte_addr[1:0], cnt[2:0]}] : spi_miso;
      end
   end
endmodule
